// File: rtl/sdram_port_arb_if.sv
// Requester-side and controller-side signal bundle for sdram_port_arb.
// master = arbiter view; slave = requesters plus controller (environment) view.
interface sdram_port_arb_if #(
  parameter int NPORT = 4,
  parameter int AW    = 25,
  parameter int DW    = 32
);
  logic [NPORT-1:0]        req_write;
  logic [NPORT-1:0]        req_read;
  logic [NPORT*AW-1:0]     req_adrs;
  logic [NPORT*DW-1:0]     req_wdata;
  logic [NPORT*DW/8-1:0]   req_de;
  logic [NPORT-1:0]        req_ack;
  logic [NPORT-1:0]        req_err;
  logic [DW-1:0]           req_rdata;
  logic                    sdram_write;
  logic                    sdram_read;
  logic [AW-1:0]           sdram_adrs;
  logic [DW-1:0]           sdram_wdata;
  logic [DW/8-1:0]         sdram_de;
  logic [DW-1:0]           sdram_rdata;
  logic                    sdram_ack;
  logic                    sdram_refresh_doing;
  logic                    sdram_err;

  modport master (
    input  req_write, req_read, req_adrs, req_wdata, req_de,
    output req_ack, req_err, req_rdata,
    output sdram_write, sdram_read, sdram_adrs, sdram_wdata, sdram_de,
    input  sdram_rdata, sdram_ack, sdram_refresh_doing, sdram_err
  );

  modport slave (
    output req_write, req_read, req_adrs, req_wdata, req_de,
    input  req_ack, req_err, req_rdata,
    input  sdram_write, sdram_read, sdram_adrs, sdram_wdata, sdram_de,
    output sdram_rdata, sdram_ack, sdram_refresh_doing, sdram_err
  );
endinterface

// File: rtl/sdram_port_arb.sv
// Round-robin N-port arbiter in front of the SDRAM controller; strobe 1 cycle after grant, req_ack 1 cycle after sdram_ack.
// Requests are held until req_ack; no issue while refresh runs. SDRAM_ARB_PRIO0_EN gives port 0 strict priority.
module sdram_port_arb #(
  parameter int NPORT   = 4,
  parameter int AW      = 25,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              m_clock,
  input  logic              p_reset,
  sdram_port_arb_if.master  bus
);
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     grant;
  logic              op_write;
  logic [CW-1:0]     tmo_cnt;
  logic [AW-1:0]     adrs_q;
  logic [DW-1:0]     wdata_q;
  logic [BW-1:0]     de_q;
  logic [DW-1:0]     rdata_q;
  logic [NPORT-1:0]  ack_q;
  logic [NPORT-1:0]  err_q;

  logic [NPORT-1:0]  cand;
  logic [NPORT-1:0]  cand_rr;
  logic              found;
  logic              prio_win;
  logic [PW-1:0]     winner;
  logic [PW-1:0]     idx;

  // Winner search: first candidate at or above rr_ptr, wrapping.
  always_comb begin
    cand     = bus.req_write | bus.req_read;
    cand_rr  = cand;
    found    = 1'b0;
    prio_win = 1'b0;
    winner   = '0;
    idx      = '0;
`ifdef SDRAM_ARB_PRIO0_EN
    cand_rr[0] = 1'b0;
`endif
    for (int i = 0; i < NPORT; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NPORT);
      if (!found && cand_rr[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
`ifdef SDRAM_ARB_PRIO0_EN
    if (cand[0]) begin
      found    = 1'b1;
      prio_win = 1'b1;
      winner   = '0;
    end
`endif
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      op_write <= 1'b0;
      tmo_cnt  <= '0;
      adrs_q   <= '0;
      wdata_q  <= '0;
      de_q     <= '0;
      rdata_q  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state)
        IDLE: begin
          if (found && !bus.sdram_refresh_doing) begin
            grant    <= winner;
            op_write <= bus.req_write[winner];
            adrs_q   <= bus.req_adrs[int'(winner)*AW +: AW];
            wdata_q  <= bus.req_wdata[int'(winner)*DW +: DW];
            de_q     <= bus.req_de[int'(winner)*BW +: BW];
            tmo_cnt  <= '0;
            if (!prio_win)
              rr_ptr <= (winner == PW'(NPORT - 1)) ? '0 : winner + 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.sdram_ack || bus.sdram_err) begin
            if (!op_write)
              rdata_q <= bus.sdram_rdata;
            ack_q[grant] <= 1'b1;
            err_q[grant] <= bus.sdram_err;
            tmo_cnt      <= '0;
            state        <= DONE;
          end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            // Watchdog: complete with error, read data left untouched.
            ack_q[grant] <= 1'b1;
            err_q[grant] <= 1'b1;
            tmo_cnt      <= '0;
            state        <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign bus.sdram_write = (state == WAIT) &  op_write;
  assign bus.sdram_read  = (state == WAIT) & ~op_write;
  assign bus.sdram_adrs  = adrs_q;
  assign bus.sdram_wdata = wdata_q;
  assign bus.sdram_de    = de_q;
  assign bus.req_ack     = ack_q;
  assign bus.req_err     = err_q;
  assign bus.req_rdata   = rdata_q;
endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb (TIMEOUT=15); round-robin or port-0 priority
// scenario chosen by SDRAM_ARB_PRIO0_EN.
module tb_sdram_port_arb;
  localparam int NPORT = 4;
  localparam int AW    = 25;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int TMO   = 15;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  sdram_port_arb_if #(.NPORT(NPORT), .AW(AW), .DW(DW)) bus ();

  sdram_port_arb #(.NPORT(NPORT), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .m_clock (clk),
    .p_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic logic [AW-1:0] port_adrs(int p);
    return AW'(32'h100 + p * 32'h11);
  endfunction

  function automatic logic [BW-1:0] port_de(int p);
    return BW'(1 << p);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.sdram_read || bus.sdram_write) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_write = '0;
    bus.req_read  = '0;
    bus.sdram_rdata = '0;
    bus.sdram_ack = 1'b0;
    bus.sdram_err = 1'b0;
    bus.sdram_refresh_doing = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      bus.req_adrs[p*AW +: AW]  = port_adrs(p);
      bus.req_wdata[p*DW +: DW] = 32'hA000_0000 | p;
      bus.req_de[p*BW +: BW]    = port_de(p);
    end
    step();
    step();
    total++; if ({bus.sdram_write, bus.sdram_read} !== 2'b00) $display("FAIL rst_strobe: got %b want 00", {bus.sdram_write, bus.sdram_read}); else passed++;
    total++; if (bus.sdram_adrs !== '0) $display("FAIL rst_adrs: got %h want 0", bus.sdram_adrs); else passed++;
    total++; if (bus.sdram_wdata !== '0) $display("FAIL rst_wdata: got %h want 0", bus.sdram_wdata); else passed++;
    total++; if (bus.sdram_de !== '0) $display("FAIL rst_de: got %h want 0", bus.sdram_de); else passed++;
    total++; if (bus.req_ack !== '0) $display("FAIL rst_ack: got %b want 0", bus.req_ack); else passed++;
    total++; if (bus.req_err !== '0) $display("FAIL rst_err: got %b want 0", bus.req_err); else passed++;
    total++; if (bus.req_rdata !== '0) $display("FAIL rst_rdata: got %h want 0", bus.req_rdata); else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    bit ok;
    int n;
    bit early;
    bus.req_adrs[2*AW +: AW] = 25'h0001234;
    bus.req_read[2] = 1'b1;
    wait_strobe(ok);
    total++; if (!ok) $display("FAIL rd_strobe_timeout: got none want strobe"); else passed++;
    total++; if ({bus.sdram_write, bus.sdram_read} !== 2'b01) $display("FAIL rd_op: got %b want 01", {bus.sdram_write, bus.sdram_read}); else passed++;
    total++; if (bus.sdram_adrs !== 25'h0001234) $display("FAIL rd_adrs: got %h want 0001234", bus.sdram_adrs); else passed++;
    n = 1;
    early = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.sdram_read) n++;
      if (bus.req_ack !== '0) early = 1'b1;
    end
    bus.sdram_ack   = 1'b1;
    bus.sdram_rdata = 32'hDEADBEEF;
    total++; if (n !== 6) $display("FAIL rd_strobe_len: got %0d want 6", n); else passed++;
    total++; if (early) $display("FAIL rd_early_ack: got ack want none"); else passed++;
    step();
    bus.sdram_ack = 1'b0;
    total++; if (bus.req_ack !== 4'b0100) $display("FAIL rd_ack: got %b want 0100", bus.req_ack); else passed++;
    total++; if (bus.req_err !== 4'b0000) $display("FAIL rd_err: got %b want 0000", bus.req_err); else passed++;
    total++; if (bus.req_rdata !== 32'hDEADBEEF) $display("FAIL rd_rdata: got %h want deadbeef", bus.req_rdata); else passed++;
    total++; if (bus.sdram_read !== 1'b0) $display("FAIL rd_strobe_done: got %b want 0", bus.sdram_read); else passed++;
    bus.req_read[2] = 1'b0;
    bus.req_adrs[2*AW +: AW] = port_adrs(2);
    step();
  endtask

  task automatic test_op_select();
    bit ok;
    bus.req_write[2] = 1'b1;
    bus.req_read[2]  = 1'b1;
    wait_strobe(ok);
    total++; if (!ok || {bus.sdram_write, bus.sdram_read} !== 2'b10) $display("FAIL opsel_write: got %b want 10", {bus.sdram_write, bus.sdram_read}); else passed++;
    total++; if (bus.sdram_wdata !== 32'hA000_0002) $display("FAIL opsel_wdata: got %h want a0000002", bus.sdram_wdata); else passed++;
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
    bus.req_write[2] = 1'b0;
    wait_strobe(ok);
    total++; if (!ok || {bus.sdram_write, bus.sdram_read} !== 2'b01) $display("FAIL opsel_read: got %b want 01", {bus.sdram_write, bus.sdram_read}); else passed++;
    bus.sdram_ack   = 1'b1;
    bus.sdram_rdata = 32'h0BADF00D;
    step();
    bus.sdram_ack = 1'b0;
    total++; if (bus.req_rdata !== 32'h0BADF00D) $display("FAIL opsel_rdata: got %h want 0badf00d", bus.req_rdata); else passed++;
    bus.req_read[2] = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    bit ok;
    int order [6];
    int g;
    order = '{0, 1, 3, 0, 1, 3};
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_write = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      g = order[k];
      wait_strobe(ok);
      total++; if (!ok || bus.sdram_write !== 1'b1) $display("FAIL rr_strobe_%0d: got %b want 1", k, bus.sdram_write); else passed++;
      total++; if (bus.sdram_adrs !== port_adrs(g)) $display("FAIL rr_adrs_%0d: got %h want %h", k, bus.sdram_adrs, port_adrs(g)); else passed++;
      total++; if (bus.sdram_de !== port_de(g)) $display("FAIL rr_de_%0d: got %b want %b", k, bus.sdram_de, port_de(g)); else passed++;
      bus.sdram_ack = 1'b1;
      step();
      bus.sdram_ack = 1'b0;
      total++; if (bus.req_ack !== 4'(1 << g)) $display("FAIL rr_ack_%0d: got %b want %b", k, bus.req_ack, 4'(1 << g)); else passed++;
    end
    bus.req_write = '0;
    step();
  endtask

  task automatic test_prio();
    bit ok;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_write = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(ok);
      total++; if (!ok || bus.sdram_adrs !== port_adrs(0)) $display("FAIL prio_adrs_%0d: got %h want %h", k, bus.sdram_adrs, port_adrs(0)); else passed++;
      bus.sdram_ack = 1'b1;
      step();
      bus.sdram_ack = 1'b0;
      total++; if (bus.req_ack !== 4'b0001) $display("FAIL prio_ack_%0d: got %b want 0001", k, bus.req_ack); else passed++;
    end
    bus.req_write[0] = 1'b0;
    wait_strobe(ok);
    total++; if (!ok || bus.sdram_adrs !== port_adrs(2)) $display("FAIL prio_p2_adrs: got %h want %h", bus.sdram_adrs, port_adrs(2)); else passed++;
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
    total++; if (bus.req_ack !== 4'b0100) $display("FAIL prio_p2_ack: got %b want 0100", bus.req_ack); else passed++;
    bus.req_write = '0;
    step();
  endtask

  task automatic test_refresh();
    int viol;
    bus.sdram_refresh_doing = 1'b1;
    bus.req_read[1] = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.sdram_read || bus.sdram_write) viol++;
    end
    bus.sdram_refresh_doing = 1'b0;
    total++; if (viol !== 0) $display("FAIL ref_blocked: got %0d strobe cycles want 0", viol); else passed++;
    step();
    total++; if (bus.sdram_read !== 1'b1) $display("FAIL ref_first_issue: got %b want 1", bus.sdram_read); else passed++;
    total++; if (bus.sdram_adrs !== port_adrs(1)) $display("FAIL ref_adrs: got %h want %h", bus.sdram_adrs, port_adrs(1)); else passed++;
    bus.sdram_ack   = 1'b1;
    bus.sdram_rdata = 32'h12345678;
    step();
    bus.sdram_ack = 1'b0;
    total++; if (bus.req_ack !== 4'b0010) $display("FAIL ref_ack: got %b want 0010", bus.req_ack); else passed++;
    bus.req_read[1] = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    bus.req_read[3] = 1'b1;
    wait_strobe(ok);
    total++; if (!ok) $display("FAIL tmo_strobe_timeout: got none want strobe"); else passed++;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.sdram_read) n++;
      else break;
    end
    total++; if (n !== TMO) $display("FAIL tmo_len: got %0d want %0d", n, TMO); else passed++;
    total++; if (bus.req_ack !== 4'b1000) $display("FAIL tmo_ack: got %b want 1000", bus.req_ack); else passed++;
    total++; if (bus.req_err !== 4'b1000) $display("FAIL tmo_err: got %b want 1000", bus.req_err); else passed++;
    total++; if (bus.req_rdata !== 32'h12345678) $display("FAIL tmo_rdata: got %h want 12345678", bus.req_rdata); else passed++;
    bus.req_read[3] = 1'b0;
    step();
    total++; if (bus.req_ack !== 4'b0000) $display("FAIL tmo_pulse: got %b want 0000", bus.req_ack); else passed++;
  endtask

  task automatic test_ack_err();
    bit ok;
    bus.req_read[0] = 1'b1;
    wait_strobe(ok);
    bus.sdram_ack   = 1'b1;
    bus.sdram_err   = 1'b1;
    bus.sdram_rdata = 32'hCAFEF00D;
    step();
    bus.sdram_ack = 1'b0;
    bus.sdram_err = 1'b0;
    total++; if (!ok || bus.req_ack !== 4'b0001) $display("FAIL ackerr_ack: got %b want 0001", bus.req_ack); else passed++;
    total++; if (bus.req_err !== 4'b0001) $display("FAIL ackerr_err: got %b want 0001", bus.req_err); else passed++;
    total++; if (bus.req_rdata !== 32'hCAFEF00D) $display("FAIL ackerr_rdata: got %h want cafef00d", bus.req_rdata); else passed++;
    bus.req_read[0] = 1'b0;
    step();
  endtask

  task automatic test_ack_at_timeout();
    bit ok;
    bus.req_read[1] = 1'b1;
    wait_strobe(ok);
    for (int i = 0; i < TMO - 1; i++) step();
    total++; if (!ok || bus.sdram_read !== 1'b1) $display("FAIL acktmo_strobe: got %b want 1", bus.sdram_read); else passed++;
    bus.sdram_ack   = 1'b1;
    bus.sdram_rdata = 32'h55AA55AA;
    step();
    bus.sdram_ack = 1'b0;
    total++; if (bus.req_ack !== 4'b0010) $display("FAIL acktmo_ack: got %b want 0010", bus.req_ack); else passed++;
    total++; if (bus.req_err !== 4'b0000) $display("FAIL acktmo_err: got %b want 0000", bus.req_err); else passed++;
    total++; if (bus.req_rdata !== 32'h55AA55AA) $display("FAIL acktmo_rdata: got %h want 55aa55aa", bus.req_rdata); else passed++;
    bus.req_read[1] = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int first;
`ifdef SDRAM_ARB_PRIO0_EN
    first = 0;
`else
    first = 2;
`endif
    bus.req_write[0] = 1'b1;
    wait_strobe(ok);
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
    bus.req_write[2] = 1'b1;
    wait_strobe(ok);
    total++; if (!ok || bus.sdram_adrs !== port_adrs(first)) $display("FAIL rstw_pre_adrs: got %h want %h", bus.sdram_adrs, port_adrs(first)); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if ({bus.sdram_write, bus.sdram_read} !== 2'b00) $display("FAIL rstw_strobe: got %b want 00", {bus.sdram_write, bus.sdram_read}); else passed++;
    step();
    total++; if (bus.req_ack !== 4'b0000) $display("FAIL rstw_noack: got %b want 0000", bus.req_ack); else passed++;
    rst = 1'b0;
    wait_strobe(ok);
    total++; if (!ok || bus.sdram_adrs !== port_adrs(0)) $display("FAIL rstw_rearb: got %h want %h", bus.sdram_adrs, port_adrs(0)); else passed++;
    bus.sdram_ack = 1'b1;
    step();
    bus.sdram_ack = 1'b0;
    total++; if (bus.req_ack !== 4'b0001) $display("FAIL rstw_ack: got %b want 0001", bus.req_ack); else passed++;
    bus.req_write = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_op_select();
`ifdef SDRAM_ARB_PRIO0_EN
    test_prio();
`else
    test_round_robin();
`endif
    test_refresh();
    test_timeout();
    test_ack_err();
    test_ack_at_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
